// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory read arbiter: FSM state encoding and
// default word/address widths.
package mem_ctrl_pkg;

    localparam int DEF_WORD_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

endpackage

// File: rtl/mem_rd_arbiter_if.sv
// Requester and memory-side bus of the read arbiter.
// The arbiter connects to the slave modport; the requesters and the memory
// model connect to the master modport.
interface mem_rd_arbiter_if
    import mem_ctrl_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

    // Requester side
    logic [1:0]            req;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [ADDR_WIDTH-1:0] len0;
    logic [ADDR_WIDTH-1:0] len1;
    logic [1:0]            gnt;
    logic                  busy;
    logic [WORD_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  rd_id;
    logic                  rd_last;

    // Memory side
    logic                  mem_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WORD_WIDTH-1:0] mem_rdata;

    modport slave (
        input  req, addr0, addr1, len0, len1, mem_rdata,
        output gnt, busy, rd_data, rd_valid, rd_id, rd_last, mem_en, mem_addr
    );

    modport master (
        output req, addr0, addr1, len0, len1, mem_rdata,
        input  gnt, busy, rd_data, rd_valid, rd_id, rd_last, mem_en, mem_addr
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way arbiter with one-hot grant.
// Default build: round-robin, the requester not granted last wins a tie and
// requester 0 wins the first tie after reset.
// With MEM_RD_ARB_FIXED_PRIO_EN defined: requester 0 always wins a tie and
// the pointer register is removed.
// Grants are only produced while en_i is high.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

`ifdef MEM_RD_ARB_FIXED_PRIO_EN

    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    // Fixed priority: requester 0 first
    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (req_i[0]) begin
                gnt_o = 2'b01;
            end else if (req_i[1]) begin
                gnt_o = 2'b10;
            end
        end
    end

`else

    logic prio_q;   // 1: requester 1 wins the next tie
    logic prio_d;

    // Round-robin grant and pointer update on every issued grant
    always_comb begin
        gnt_o  = 2'b00;
        prio_d = prio_q;
        if (en_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = prio_q ? 2'b10 : 2'b01;
                default: gnt_o = 2'b00;
            endcase
        end
        if (gnt_o != 2'b00) begin
            prio_d = gnt_o[0];
        end
    end

    // Pointer register, favours requester 0 out of reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

`endif

endmodule

// File: rtl/mem_rd_arbiter.sv
// Two-requester burst read arbiter in front of an external synchronous
// memory (one-cycle read latency). A granted requester gets len+1
// consecutive reads starting at its address (wrapping at the top of the
// address space); data returns through a one-stage valid/id/last pipeline.
// Tie-break policy is selected by MEM_RD_ARB_FIXED_PRIO_EN (see rr_arb2).
module mem_rd_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    mem_rd_arbiter_if.slave    bus
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_WIDTH-1:0] remain_q, remain_d;
    logic                  owner_q, owner_d;
    logic                  rd_valid_q, rd_id_q, rd_last_q;
    logic [1:0]            gnt;
    logic                  grant_en;
    logic                  issue;

    // Grants only from IDLE and never while reset is asserted
    assign grant_en = (state_q == IDLE) && rst;
    assign issue    = (state_q == BURST);

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i (bus.req),
        .en_i  (grant_en),
        .gnt_o (gnt)
    );

    // Next-state: accept a grant in IDLE, walk the burst in BURST
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would infer a latch.
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        remain_d   = remain_q;
        owner_d    = owner_q;
        case (state_q)
            IDLE: begin
                if (gnt != 2'b00) begin
                    state_d    = BURST;
                    owner_d    = gnt[1];
                    cur_addr_d = gnt[1] ? bus.addr1 : bus.addr0;
                    remain_d   = gnt[1] ? bus.len1  : bus.len0;
                end
            end
            BURST: begin
                if (remain_q == '0) begin
                    // Address is left on the last issued word so mem_addr
                    // holds it through IDLE.
                    state_d = IDLE;
                end else begin
                    cur_addr_d = cur_addr_q + ADDR_WIDTH'(1);
                    remain_d   = remain_q - ADDR_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, burst counters and the one-stage return pipeline
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples values from
        // before this edge, independent of statement order.
        if (!rst) begin
            state_q    <= IDLE;
            cur_addr_q <= '0;
            remain_q   <= '0;
            owner_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_id_q    <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            remain_q   <= remain_d;
            owner_q    <= owner_d;
            rd_valid_q <= issue;
            rd_id_q    <= owner_q;
            rd_last_q  <= issue && (remain_q == '0);
        end
    end

    // mem_en decodes a single state flop, so it is glitch-free for the
    // memory clock gate.
    assign bus.mem_en   = issue;
    assign bus.mem_addr = cur_addr_q;
    assign bus.gnt      = gnt;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_id    = rd_id_q;
    assign bus.rd_last  = rd_last_q;
    assign bus.rd_data  = rd_valid_q ? bus.mem_rdata : '0;
    assign bus.busy     = issue | rd_valid_q;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed testbench for mem_rd_arbiter with a preloaded 16-word memory
// model (mem[i] = i*0x11, one-cycle read latency).
// Inputs change 1 ns after the rising edge, outputs are sampled on the
// falling edge.
module tb_mem_rd_arbiter;

`ifdef MEM_RD_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    typedef struct packed {
        logic        en;
        logic [3:0]  addr;
        logic        rv;
        logic        last;
        logic [15:0] data;
    } row_t;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    mem_rd_arbiter_if #(.WORD_WIDTH(16), .ADDR_WIDTH(4)) bus ();

    mem_rd_arbiter #(.WORD_WIDTH(16), .ADDR_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] mem [16];

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'(i * 16'h11);
    end

    always @(posedge clk) begin
        if (bus.mem_en) bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Walks a table of per-cycle expectations following a grant.
    task automatic test_rows(input string name, input row_t rows_in[$], input logic id);
        row_t rows[$];
        row_t r;
        int   k;
        rows = rows_in;
        k = 1;
        while (rows.size() > 0) begin
            r = rows.pop_front();
            next_cycle();
            bus.req = 2'b00;
            @(negedge clk);
            vectors++;
            if ({bus.mem_en, bus.mem_addr} !== {r.en, r.addr}) begin
                miscompares++;
                $display("FAIL %s issue c%0d: got en/addr %b/%0d want %b/%0d",
                         name, k, bus.mem_en, bus.mem_addr, r.en, r.addr);
            end
            vectors++;
            if ({bus.rd_valid, bus.rd_last, bus.rd_data} !== {r.rv, r.last, r.data}) begin
                miscompares++;
                $display("FAIL %s return c%0d: got valid/last/data %b/%b/%h want %b/%b/%h",
                         name, k, bus.rd_valid, bus.rd_last, bus.rd_data, r.rv, r.last, r.data);
            end
            vectors++;
            if (bus.busy !== (r.en | r.rv)) begin
                miscompares++;
                $display("FAIL %s busy c%0d: got %b want %b", name, k, bus.busy, r.en | r.rv);
            end
            if (r.rv) begin
                vectors++;
                if (bus.rd_id !== id) begin
                    miscompares++;
                    $display("FAIL %s rd_id c%0d: got %b want %b", name, k, bus.rd_id, id);
                end
            end
            k++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.req = 2'b00; bus.addr0 = '0; bus.addr1 = '0; bus.len0 = '0; bus.len1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({bus.gnt, bus.busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset gnt/busy: got %b/%b want 00/0", bus.gnt, bus.busy);
        end
        vectors++;
        if ({bus.mem_en, bus.mem_addr} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset mem: got en/addr %b/%0d want 0/0", bus.mem_en, bus.mem_addr);
        end
        vectors++;
        if ({bus.rd_valid, bus.rd_last, bus.rd_id, bus.rd_data} !== 19'b0) begin
            miscompares++;
            $display("FAIL reset return: got v/l/id/data %b/%b/%b/%h want 0/0/0/0000",
                     bus.rd_valid, bus.rd_last, bus.rd_id, bus.rd_data);
        end
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus.gnt, bus.mem_en, bus.busy} !== 4'b0000) begin
            miscompares++;
            $display("FAIL post-reset idle: got gnt/en/busy %b/%b/%b want 00/0/0",
                     bus.gnt, bus.mem_en, bus.busy);
        end
    endtask

    // Issues one request on the given requester and checks the grant pulse.
    task automatic request(input string name, input logic [1:0] r, input logic [3:0] a,
                           input logic [3:0] l, input logic [1:0] exp_gnt);
        next_cycle();
        bus.req = r;
        if (r[1]) begin bus.addr1 = a; bus.len1 = l; end
        else      begin bus.addr0 = a; bus.len0 = l; end
        @(negedge clk);
        vectors++;
        if (bus.gnt !== exp_gnt) begin
            miscompares++;
            $display("FAIL %s gnt: got %b want %b", name, bus.gnt, exp_gnt);
        end
    endtask

    task automatic test_single();
        row_t rows[$] = '{
            '{1'b1, 4'd3, 1'b0, 1'b0, 16'h0000},
            '{1'b1, 4'd4, 1'b1, 1'b0, 16'h0033},
            '{1'b1, 4'd5, 1'b1, 1'b0, 16'h0044},
            '{1'b0, 4'd5, 1'b1, 1'b1, 16'h0055},
            '{1'b0, 4'd5, 1'b0, 1'b0, 16'h0000}
        };
        request("single", 2'b01, 4'd3, 4'd2, 2'b01);
        test_rows("single", rows, 1'b0);
    endtask

    task automatic test_wrap();
        row_t rows[$] = '{
            '{1'b1, 4'd14, 1'b0, 1'b0, 16'h0000},
            '{1'b1, 4'd15, 1'b1, 1'b0, 16'h00EE},
            '{1'b1, 4'd0,  1'b1, 1'b0, 16'h00FF},
            '{1'b1, 4'd1,  1'b1, 1'b0, 16'h0000},
            '{1'b0, 4'd1,  1'b1, 1'b1, 16'h0011},
            '{1'b0, 4'd1,  1'b0, 1'b0, 16'h0000}
        };
        request("wrap", 2'b10, 4'd14, 4'd3, 2'b10);
        test_rows("wrap", rows, 1'b1);
    endtask

    task automatic test_req_during_burst();
        request("mid_req", 2'b01, 4'd0, 4'd3, 2'b01);
        bus.addr1 = 4'd5; bus.len1 = 4'd0;
        for (int k = 1; k <= 5; k++) begin
            next_cycle();
            bus.req = 2'b10;
            @(negedge clk);
            vectors++;
            if ({bus.gnt, bus.mem_en} !== {((k == 5) ? 2'b10 : 2'b00), (k < 5)}) begin
                miscompares++;
                $display("FAIL mid_req c%0d: got gnt/en %b/%b want %b/%b",
                         k, bus.gnt, bus.mem_en, (k == 5) ? 2'b10 : 2'b00, k < 5);
            end
        end
        next_cycle();
        bus.req = 2'b00;
        next_cycle();
        @(negedge clk);
        vectors++;
        if ({bus.rd_valid, bus.rd_last, bus.rd_id, bus.rd_data} !== {3'b111, 16'h0055}) begin
            miscompares++;
            $display("FAIL mid_req return: got v/l/id/data %b/%b/%b/%h want 1/1/1/0055",
                     bus.rd_valid, bus.rd_last, bus.rd_id, bus.rd_data);
        end
        repeat (2) next_cycle();
    endtask

    task automatic test_long_burst();
        request("long", 2'b01, 4'd0, 4'd15, 2'b01);
        for (int k = 1; k <= 18; k++) begin
            next_cycle();
            bus.req = 2'b00;
            @(negedge clk);
            vectors++;
            if ({bus.mem_en, bus.mem_addr} !== {(k <= 16), ((k <= 16) ? 4'(k - 1) : 4'd15)}) begin
                miscompares++;
                $display("FAIL long issue c%0d: got en/addr %b/%0d want %b/%0d",
                         k, bus.mem_en, bus.mem_addr, k <= 16, (k <= 16) ? k - 1 : 15);
            end
            vectors++;
            if ({bus.rd_valid, bus.rd_last} !== {(k >= 2 && k <= 17), (k == 17)}) begin
                miscompares++;
                $display("FAIL long valid/last c%0d: got %b/%b want %b/%b",
                         k, bus.rd_valid, bus.rd_last, k >= 2 && k <= 17, k == 17);
            end
            if (k >= 2 && k <= 17) begin
                vectors++;
                if (bus.rd_data !== 16'((k - 2) * 16'h11)) begin
                    miscompares++;
                    $display("FAIL long data c%0d: got %h want %h", k, bus.rd_data, 16'((k - 2) * 16'h11));
                end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] e_gnt [5];
        e_gnt = '{2'b01, 2'b00, FIXED ? 2'b01 : 2'b10, 2'b00, 2'b01};
        next_cycle();
        rst = 1'b0;
        bus.req = 2'b11; bus.addr0 = 4'd2; bus.addr1 = 4'd9; bus.len0 = 4'd0; bus.len1 = 4'd0;
        next_cycle();
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) next_cycle();
            @(negedge clk);
            vectors++;
            if (bus.gnt !== e_gnt[k]) begin
                miscompares++;
                $display("FAIL rr gnt c%0d: got %b want %b", k, bus.gnt, e_gnt[k]);
            end
            if (k == 2) begin
                vectors++;
                if ({bus.rd_valid, bus.rd_last, bus.rd_id, bus.rd_data, bus.busy} !== {3'b110, 16'h0022, 1'b1}) begin
                    miscompares++;
                    $display("FAIL rr overlap return: got v/l/id/data/busy %b/%b/%b/%h/%b want 1/1/0/0022/1",
                             bus.rd_valid, bus.rd_last, bus.rd_id, bus.rd_data, bus.busy);
                end
            end
            if (k == 3) begin
                vectors++;
                if ({bus.mem_en, bus.mem_addr} !== {1'b1, FIXED ? 4'd2 : 4'd9}) begin
                    miscompares++;
                    $display("FAIL rr second issue: got en/addr %b/%0d want 1/%0d",
                             bus.mem_en, bus.mem_addr, FIXED ? 2 : 9);
                end
            end
            if (k == 4) begin
                vectors++;
                if ({bus.rd_valid, bus.rd_id, bus.rd_data} !== {1'b1, ~FIXED, FIXED ? 16'h0022 : 16'h0099}) begin
                    miscompares++;
                    $display("FAIL rr second return: got v/id/data %b/%b/%h want 1/%b/%h",
                             bus.rd_valid, bus.rd_id, bus.rd_data, ~FIXED, FIXED ? 16'h0022 : 16'h0099);
                end
            end
        end
        next_cycle();
        bus.req = 2'b00;
        repeat (3) next_cycle();
    endtask

    task automatic test_reset_mid_burst();
        row_t rows[$] = '{
            '{1'b1, 4'd7, 1'b0, 1'b0, 16'h0000},
            '{1'b0, 4'd7, 1'b1, 1'b1, 16'h0077},
            '{1'b0, 4'd7, 1'b0, 1'b0, 16'h0000}
        };
        request("rst_mid", 2'b01, 4'd4, 4'd5, 2'b01);
        next_cycle();
        bus.req = 2'b00;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus.mem_en, bus.mem_addr} !== {1'b1, 4'd5}) begin
            miscompares++;
            $display("FAIL rst_mid before edge: got en/addr %b/%0d want 1/5", bus.mem_en, bus.mem_addr);
        end
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus.mem_en, bus.rd_valid, bus.busy, bus.mem_addr, bus.rd_data} !== 23'b0) begin
            miscompares++;
            $display("FAIL rst_mid after edge: got en/valid/busy/addr/data %b/%b/%b/%0d/%h want 0/0/0/0/0000",
                     bus.mem_en, bus.rd_valid, bus.busy, bus.mem_addr, bus.rd_data);
        end
        request("rst_mid fresh", 2'b10, 4'd7, 4'd0, 2'b10);
        vectors++;
        if ({bus.mem_en, bus.rd_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL rst_mid in-flight: got en/valid %b/%b want 0/0", bus.mem_en, bus.rd_valid);
        end
        test_rows("rst_mid fresh", rows, 1'b1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_req_during_burst();
        test_long_burst();
        test_round_robin();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete within 100000 ns");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_rd_arbiter.md
MEM_RD_ARBITER -- requirements
Module: mem_rd_arbiter

Interface
REQ-001 Parameter WORD_WIDTH, default 16, is the memory word and read-data width.
REQ-002 Parameter ADDR_WIDTH, default 4, is the memory address width; depth is 2**ADDR_WIDTH.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 req  in  2  per-requester read request; held high by requester until its gnt bit pulses.
REQ-006 addr0, addr1  in  ADDR_WIDTH  burst start address for requester 0 / 1.
REQ-007 len0, len1  in  ADDR_WIDTH  burst length minus one for requester 0 / 1 (0 = one word).
REQ-008 gnt  out  2  one-hot, one-cycle grant pulse; addr/len sampled in that cycle.
REQ-009 busy  out  1  high while a burst is issuing or its data is still returning.
REQ-010 mem_en  out  1  memory read enable; memory clock gating uses this signal.
REQ-011 mem_addr  out  ADDR_WIDTH  memory read address, valid when mem_en=1.
REQ-012 mem_rdata  in  WORD_WIDTH  memory read data, one cycle after mem_en/mem_addr.
REQ-013 rd_data  out  WORD_WIDTH  returned word; rd_valid  out 1; rd_id  out 1 owner; rd_last  out 1 final word of burst.

Function
REQ-014 FSM states IDLE and BURST only; return of data handled by a one-stage valid/id/last pipeline.
REQ-015 IDLE with any req bit set: grant one winner, latch its addr and len into cur_addr/remain, go BURST next cycle.
REQ-016 Arbitration round-robin: single request wins; both requesting -> requester not granted last wins; after reset requester 0 wins first tie.
REQ-017 req is ignored in BURST and in the gnt cycle for the non-winner; loser keeps req high and is granted in a later IDLE.
REQ-018 BURST: mem_en=1, mem_addr=cur_addr each cycle; cur_addr increments modulo 2**ADDR_WIDTH (15 -> 0 wraps); remain decrements.
REQ-019 BURST with remain=0: issue last read, go IDLE next cycle; no idle mem_en gaps inside a burst.
REQ-020 mem_en=0 and mem_addr holds its last value in IDLE.
REQ-021 rd_valid/rd_id/rd_last are mem_en/owner/last-issue delayed one cycle; rd_data=mem_rdata combinationally while rd_valid=1, else 0.
REQ-022 Latency: gnt at cycle T -> first mem_en T+1 -> first rd_valid T+2 -> rd_last at T+2+len.
REQ-023 Back-to-back: next gnt may occur the cycle after the last BURST cycle (one idle issue cycle between bursts); trailing rd_valid overlaps that gnt cycle.
REQ-024 busy = (state==BURST) | rd_valid.

Reset
REQ-025 rst=0 at a rising edge: state IDLE, gnt=0, mem_en=0, mem_addr=0, rd_valid=0, rd_last=0, rd_id=0, rd_data=0, busy=0, round-robin pointer favours requester 0.
REQ-026 Reset mid-burst aborts it: no further mem_en or rd_valid after the reset edge, including the in-flight word.

Configuration
REQ-027 Macro MEM_RD_ARB_FIXED_PRIO_EN defined: requester 0 always wins ties (fixed priority), pointer logic removed.
REQ-028 Macro undefined: round-robin per REQ-016.

Structure
REQ-029 Shared package mem_ctrl_pkg holds the FSM state typedef (IDLE, BURST) and default WORD_WIDTH/ADDR_WIDTH constants.
REQ-030 One sub-module rr_arb2 (2-way round-robin/fixed-priority arbiter, one-hot grant, pointer update on grant); memory array stays external.

Verification
REQ-031 Memory preloaded mem[i]=i*0x11; req=01, addr0=3, len0=2 -> gnt=01, rd_valid three cycles, rd_data 0x33,0x44,0x55, rd_id=0, rd_last on 0x55.
REQ-032 req=10, addr1=14, len1=3 -> mem_addr 14,15,0,1 (wrap), rd_data 0xEE,0xFF,0x00,0x11.
REQ-033 req=11 held from reset, len0=len1=0 -> gnt 01 then 10 then 01; with MEM_RD_ARB_FIXED_PRIO_EN -> 01 every grant.
REQ-034 New req during BURST -> no gnt until IDLE; gnt exactly the cycle after last mem_en.
REQ-035 rst=0 in second BURST cycle of len0=5 burst -> next cycle mem_en=0, rd_valid=0, busy=0; after release a fresh req is granted normally.
REQ-036 len0=15, addr0=0 -> 16 consecutive mem_en cycles, mem_addr 0..15, rd_last only on 16th word.
